data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits in the Memory stage between the EX/MEM pipeline register and a slower backing data memory.
- Consumes the stage's address, store data, load/store mode and read/write strobes; returns load data and a stall to the hazard logic.
- Refills lines word-by-word over a req/ack handshake.

Parameters:
- WIDTH, 32, data/address width.
- SETS, 64, number of lines; power of two.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_re  input  1  load strobe (MemRead in the Memory stage).
- cpu_we  input  1  store strobe (MemWrite in the Memory stage).
- modeAddr  input  3  funct3 access mode: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- A  input  WIDTH  byte address.
- WD  input  WIDTH  store data, right-aligned.
- RD  output  WIDTH  load data, extended per modeAddr.
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB.
- mem_req  output  1  backing-memory request.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  WIDTH  word-aligned address.
- mem_wdata  output  WIDTH  write data, lane-aligned.
- mem_be  output  4  byte enables (writes only).
- mem_rdata  input  WIDTH  read data, valid when mem_ack=1.
- mem_ack  input  1  one-cycle completion pulse.

Behaviour:
- Address split (defaults): byte A[1:0], word A[3:2], index A[9:4], tag A[31:10]. Widths derive from the parameters.
- Storage per line: valid bit, tag, WORDS_PER_LINE data words. Hit means valid and tag equal.
- Reset (rst=0, async): every valid bit cleared, FSM to IDLE, counter 0. stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be and RD all 0. Data array is not reset.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, cpu_we=1: go to WRITE. cpu_we has priority over cpu_re; cpu_re is ignored that cycle.
- IDLE, cpu_re=1 and miss: go to REFILL, refill counter = 0.
- IDLE, cpu_re=1 and hit: stay in IDLE.
- Hit load: RD is combinational in the same cycle; stall=0.
- Load extraction: LB/LBU take lane A[1:0]; LH/LHU take half A[1]; LW ignores A[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- stall (combinational) = (cpu_re & miss & state==IDLE) | (cpu_we & state==IDLE) | state!=IDLE. Exception: stall drops in the return-to-IDLE cycle described below.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, counter, 2'b00}.
  - On each mem_ack: write mem_rdata into word[counter], increment counter.
  - On the ack of word WORDS_PER_LINE-1: set tag and valid, go to IDLE.
  - The following cycle is a hit with stall=0.
  - Minimum miss penalty is WORDS_PER_LINE+1 cycles (ack every cycle).
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = {A[31:2],2'b00}.
  - mem_wdata has the byte replicated to all 4 lanes (SB), the half to both halves (SH), or the full word (SW).
  - mem_be is 0001<<A[1:0] (SB), 0011<<{A[1],1'b0} (SH), or 1111 (SW).
  - On mem_ack: if the line hits, merge the same bytes into the cached word. On a miss, no allocate. Then go to IDLE.
  - The store retires with stall=0 in the cycle after the ack.
- Handshake: while mem_req=1, mem_addr/mem_we/mem_wdata/mem_be stay stable until mem_ack is sampled. mem_req drops in the cycle after the final ack. mem_ack with mem_req=0 is ignored.
- The stage inputs are held stable by stall, so the cache does not latch A/WD.
- rst asserted mid-REFILL: refill abandoned, line stays invalid, mem_req low immediately. A late mem_ack after reset is ignored.
- Conflict: a refill of an index overwrites the previous tag (direct-mapped eviction, no writeback needed).
- Undefined modeAddr values (011, 110, 111): treated as word access.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- When defined: adds outputs hit_count and miss_count (32 bits each).
  - hit_count counts cycles in IDLE with cpu_re=1 and a hit.
  - miss_count counts transitions into REFILL.
  - Both reset to 0 asynchronously and wrap modulo 2^32.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold LW A=0x100, memory words 0x100..0x10C = 11,22,33,44, ack every cycle -> stall high 5 cycles, 4 reads at 0x100,0x104,0x108,0x10C, then RD=0x11 with stall=0; LW 0x108 next -> RD=0x33, no mem_req.
- SB WD=0x000000AB to hit address 0x101 -> mem_be=0010, mem_wdata=0xABABABAB, mem_addr=0x100; LBU 0x101 -> 0x000000AB; LB 0x101 -> 0xFFFFFFAB.
- SW to uncached 0x2000 -> one write transaction; following LW 0x2000 misses and refills (no allocate on store).
- LW 0x100 then LW 0x500 (same index, different tag) then LW 0x100 -> three refills, miss_count=3 when DCACHE_PERF_CNT_EN is defined.
- Assert rst=0 after the 2nd ack of a refill -> mem_req=0 and stall=0 immediately; after release, LW of the same address misses again.
- LH 0x102 with word 0x8001xxxx -> RD=0xFFFF8001; LHU -> 0x00008001; ack delayed 3 cycles per word -> stall held and address stable throughout.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Optional perf counters (hit_count/miss_count) enabled by DCACHE_PERF_CNT_EN.
module data_cache #(
    parameter int WIDTH          = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [2:0]       modeAddr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] WD,
    output logic [WIDTH-1:0] RD,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WIDTH - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

    state_e             state_q, state_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [WIDTH-1:0]   data_q [SETS*WORDS_PER_LINE];

    logic [TAG_W-1:0]   a_tag;
    logic [IDX_W-1:0]   a_idx;
    logic [OFF_W-1:0]   a_word;
    logic               hit;
    logic [WIDTH-1:0]   rd_word;
    logic [7:0]         ld_b;
    logic [15:0]        ld_h;
    logic [WIDTH-1:0]   ld_val;
    logic [WIDTH-1:0]   st_data;
    logic [3:0]         st_be;
    logic [WIDTH-1:0]   wr_word;
    logic               refill_wr;
    logic               store_wr;
    logic               miss_start;

    assign a_tag   = A[WIDTH-1 -: TAG_W];
    assign a_idx   = A[OFF_W+2 +: IDX_W];
    assign a_word  = A[2 +: OFF_W];
    assign hit     = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign rd_word = data_q[{a_idx, a_word}];
    assign ld_b    = rd_word[{A[1:0], 3'b000} +: 8];
    assign ld_h    = rd_word[{A[1], 4'b0000} +: 16];

    // Load extraction and sign/zero extension by access mode
    always_comb begin
        ld_val = rd_word;
        case (modeAddr)
            3'b000:  ld_val = {{(WIDTH-8){ld_b[7]}}, ld_b};
            3'b100:  ld_val = {{(WIDTH-8){1'b0}}, ld_b};
            3'b001:  ld_val = {{(WIDTH-16){ld_h[15]}}, ld_h};
            3'b101:  ld_val = {{(WIDTH-16){1'b0}}, ld_h};
            default: ld_val = rd_word;
        endcase
    end

    // Only a resolved hit load drives RD; zero otherwise (including reset)
    assign RD = (rst && cpu_re && hit && state_q == IDLE) ? ld_val : '0;

    // Store lane replication and byte enables
    always_comb begin
        st_data = WD;
        st_be   = 4'b1111;
        case (modeAddr)
            3'b000: begin
                st_data = {4{WD[7:0]}};
                st_be   = 4'b0001 << A[1:0];
            end
            3'b001: begin
                st_data = {2{WD[15:0]}};
                st_be   = 4'b0011 << {A[1], 1'b0};
            end
            default: begin
                st_data = WD;
                st_be   = 4'b1111;
            end
        endcase
    end

    // Merge stored bytes into the cached word for a write hit
    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (st_be[b]) wr_word[8*b +: 8] = st_data[8*b +: 8];
        end
    end

    // Next-state and memory-port outputs; done_q marks the retire cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = 4'b0000;
        refill_wr  = 1'b0;
        store_wr   = 1'b0;
        miss_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!done_q) begin
                    if (cpu_we) begin
                        state_d = WRITE;
                        stall   = 1'b1;
                    end else if (cpu_re && !hit) begin
                        state_d    = REFILL;
                        cnt_d      = '0;
                        stall      = 1'b1;
                        miss_start = 1'b1;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {A[WIDTH-1:OFF_W+2], cnt_q, 2'b00};
                if (mem_ack) begin
                    refill_wr = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {A[WIDTH-1:2], 2'b00};
                mem_wdata = st_data;
                mem_be    = st_be;
                if (mem_ack) begin
                    store_wr = hit;
                    state_d  = IDLE;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst) stall = 1'b0;
    end

    // Control state and valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (refill_wr && cnt_q == LAST) valid_q[a_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset
    always_ff @(posedge clk) begin
        if (refill_wr) begin
            data_q[{a_idx, cnt_q}] <= mem_rdata;
            if (cnt_q == LAST) tag_q[a_idx] <= a_tag;
        end else if (store_wr) begin
            data_q[{a_idx, a_word}] <= wr_word;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Hit cycles and refill starts, wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && cpu_re && hit) hit_cnt_q <= hit_cnt_q + 1;
            if (miss_start) miss_cnt_q <= miss_cnt_q + 1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache against a behavioural cache/memory model.
// Perf counter checks are compiled in when DCACHE_PERF_CNT_EN is defined.
module tb_data_cache;

    localparam int WPL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  modeAddr = 3'b010;
    logic [31:0] A = '0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    data_cache dut (
        .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .modeAddr(modeAddr), .A(A), .WD(WD), .RD(RD), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Backing memory and responder
    logic [31:0] bmem [4096];
    int ack_delay = 0;
    int wait_cnt = 0;
    bit force_ack = 1'b0;
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    logic [3:0]  log_b[$];
    logic        log_w[$];
    bit          hold_v = 1'b0;
    logic [31:0] hold_a, hold_d;
    logic [3:0]  hold_b;
    logic        hold_w;
    int          unstable = 0;

    assign mem_ack   = (mem_req && wait_cnt == ack_delay) || force_ack;
    assign mem_rdata = bmem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (mem_req && hold_v &&
            (mem_addr != hold_a || mem_we != hold_w ||
             mem_wdata != hold_d || mem_be != hold_b))
            unstable++;
        if (mem_req && !mem_ack) begin
            hold_v = 1'b1; hold_a = mem_addr; hold_w = mem_we;
            hold_d = mem_wdata; hold_b = mem_be;
        end else begin
            hold_v = 1'b0;
        end
        if (mem_req && mem_ack) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_wdata);
            log_b.push_back(mem_be);
            log_w.push_back(mem_we);
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) bmem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // Reference model: which lines are resident, plus architectural memory
    logic [31:0] ref_mem [4096];
    bit          mval [64];
    int          mtag [64];
    int          exp_miss = 0;
    int          exp_hit = 0;

    function automatic logic [31:0] ld_exp(input logic [31:0] w,
                                           input logic [2:0] md,
                                           input logic [31:0] a);
        logic [31:0] v;
        case (md)
            3'b000, 3'b100: begin
                v = (w >> (8 * a[1:0])) & 32'hFF;
                if (md == 3'b000 && v >= 32'h80) v = v | 32'hFFFFFF00;
            end
            3'b001, 3'b101: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (md == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] be_exp(input logic [2:0] md,
                                          input logic [31:0] a);
        case (md)
            3'b000:  return 4'(1 << a[1:0]);
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wd_exp(input logic [2:0] md,
                                           input logic [31:0] d);
        case (md)
            3'b000:  return (d & 32'hFF) * 32'h01010101;
            3'b001:  return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mval[i] = 1'b0;
        exp_miss = 0;
        exp_hit = 0;
    endtask

    task automatic op(input bit re, input bit we, input logic [2:0] md,
                      input logic [31:0] a, input logic [31:0] wd);
        int cyc, exp_cyc, idx, n;
        bit hit;
        logic [31:0] ew;
        logic [3:0]  eb;
        idx = int'(a[9:4]);
        hit = mval[idx] && mtag[idx] == int'(a[31:10]);
        log_a.delete(); log_d.delete(); log_b.delete(); log_w.delete();
        cpu_re = re; cpu_we = we; modeAddr = md; A = a; WD = wd;
        cyc = 0;
        #1;
        while (stall !== 1'b0 && cyc < 400) begin
            @(negedge clk); #1; cyc++;
        end
        if (cyc >= 400) check("timeout", 32'(cyc), 32'd0);
        if (we) exp_cyc = 2 + ack_delay;
        else if (!hit) exp_cyc = 1 + WPL * (ack_delay + 1);
        else exp_cyc = 0;
        check("stall_cycles", 32'(cyc), 32'(exp_cyc));
        n = log_a.size();
        if (we) begin
            ew = wd_exp(md, wd);
            eb = be_exp(md, a);
            check("wr_count", 32'(n), 32'd1);
            if (n > 0) begin
                check("wr_addr", log_a[0], {a[31:2], 2'b00});
                check("wr_we", 32'(log_w[0]), 32'd1);
                check("wr_data", log_d[0], ew);
                check("wr_be", 32'(log_b[0]), 32'(eb));
            end
            for (int b = 0; b < 4; b++)
                if (eb[b]) ref_mem[a[13:2]][8*b +: 8] = ew[8*b +: 8];
        end else begin
            if (!hit) begin
                check("rf_count", 32'(n), 32'(WPL));
                for (int k = 0; k < n && k < WPL; k++) begin
                    check("rf_addr", log_a[k], {a[31:4], 4'b0000} + 32'(4 * k));
                    check("rf_we", 32'(log_w[k]), 32'd0);
                end
                mval[idx] = 1'b1;
                mtag[idx] = int'(a[31:10]);
                exp_miss++;
            end else begin
                check("hit_noreq", 32'(n), 32'd0);
            end
            exp_hit++;
            check("rd", RD, ld_exp(ref_mem[a[13:2]], md, a));
        end
        @(negedge clk);
        cpu_re = 1'b0; cpu_we = 1'b0;
    endtask

    logic [2:0] ld_modes [8];
    logic [2:0] st_modes [3];

    initial begin
        int cnt;
        logic [31:0] a;
        logic [2:0]  md;
        ld_modes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        st_modes = '{3'b000, 3'b001, 3'b010};
        for (int i = 0; i < 4096; i++) begin
            bmem[i] = $urandom;
            ref_mem[i] = bmem[i];
        end
        for (int i = 0; i < 4; i++) begin
            bmem[32'h40 + i] = 32'h11 * (i + 1);
            ref_mem[32'h40 + i] = 32'h11 * (i + 1);
        end
        bmem[32'hC0] = 32'h8001_1234;
        ref_mem[32'hC0] = 32'h8001_1234;
        model_reset();

        // Outputs under reset with a load strobe held
        cpu_re = 1'b1; A = 32'h100;
        @(negedge clk); #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_rd", RD, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        cpu_re = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Cold load, hit load, byte store and byte loads
        op(1, 0, 3'b010, 32'h100, 0);
        op(1, 0, 3'b010, 32'h108, 0);
        op(0, 1, 3'b000, 32'h101, 32'h0000_00AB);
        op(1, 0, 3'b100, 32'h101, 0);
        op(1, 0, 3'b000, 32'h101, 0);
        // Store to uncached line does not allocate
        op(0, 1, 3'b010, 32'h2000, 32'hCAFE_F00D);
        op(1, 0, 3'b010, 32'h2000, 0);
        // Half loads with slow acknowledge
        ack_delay = 3;
        op(1, 0, 3'b001, 32'h302, 0);
        op(1, 0, 3'b101, 32'h302, 0);
        ack_delay = 0;

        // Reset in the middle of a refill, then a stray acknowledge
        cpu_re = 1'b1; modeAddr = 3'b010; A = 32'h700;
        log_a.delete(); log_d.delete(); log_b.delete(); log_w.delete();
        cnt = 0;
        while (log_a.size() < 2 && cnt < 50) begin
            @(negedge clk); cnt++;
        end
        check("mid_acks", 32'(log_a.size()), 32'd2);
        rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        cpu_re = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        #1;
        check("late_ack_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        model_reset();

        // Direct-mapped conflict on one index
        op(1, 0, 3'b010, 32'h100, 0);
        op(1, 0, 3'b010, 32'h500, 0);
        op(1, 0, 3'b010, 32'h100, 0);
`ifdef DCACHE_PERF_CNT_EN
        check("miss_count_conflict", miss_count, 32'd3);
`endif
        op(1, 0, 3'b010, 32'h700, 0);

        // Randomized mix of loads and stores over a few tags and indexes
        for (int t = 0; t < 200; t++) begin
            ack_delay = $urandom_range(0, 2);
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) |
                $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) begin
                md = st_modes[$urandom_range(0, 2)];
                if (md == 3'b001) a = a & ~32'h1;
                else if (md != 3'b000) a = a & ~32'h3;
                op(0, 1, md, a, $urandom);
            end else begin
                md = ld_modes[$urandom_range(0, 7)];
                if (md == 3'b001 || md == 3'b101) a = a & ~32'h1;
                else if (md != 3'b000 && md != 3'b100) a = a & ~32'h3;
                op(1, 0, md, a, 0);
            end
        end
        ack_delay = 0;

        check("addr_stable", 32'(unstable), 32'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("miss_count", miss_count, 32'(exp_miss));
        check("hit_count", hit_count, 32'(exp_hit));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
